ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver with a buffered read port, the next generation of the keyboard input path of the `squares` system. It synchronises the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames: start, 8 data bits LSB first, odd parity, stop. Received bytes go into a depth-configurable show-ahead FIFO drained through a valid/ready port. Framing, parity, timeout and overflow errors are reported to the game logic / LED status path.

---
 rtl/ps2_rx_fifo.sv | 173 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, 11-bit frame deframer and show-ahead byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to drop bytes with bad odd parity and drive parity_err.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         frame_err,
  output logic                         parity_err,
  input  logic                         clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_hist;
  logic                   fe, data_s, timeout;
  logic [7:0]             shift;
  logic [2:0]             bit_cnt;
  logic [WW-1:0]          wd_cnt;
  logic                   push, frame_err_d;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   full, pop, wr_en;

  // Synchronisers reset to 1 (idle bus level) so release from reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_hist  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe      = clk_hist & ~clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && !fe && (wd_cnt == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fe && !data_s)          next_state = DATA;
      DATA:    if (fe && bit_cnt == 3'd7)  next_state = PARITY;
      PARITY:  if (fe)                     next_state = STOP;
      STOP:    if (fe)                     next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
    if (timeout) next_state = IDLE;
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit, parity_ok, parity_err_d;
  assign parity_ok = ^{shift, par_bit};
`endif

  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    case (state)
      IDLE: frame_err_d = fe & data_s;
      STOP: if (fe) begin
        if (data_s) begin
`ifdef PS2_RX_PARITY_CHECK_EN
          push = parity_ok;
`else
          push = 1'b1;
`endif
        end else begin
          frame_err_d = 1'b1;
        end
`ifdef PS2_RX_PARITY_CHECK_EN
        parity_err_d = ~parity_ok;
`endif
      end
      default: ;
    endcase
    if (timeout) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      wd_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err_d;
      if (state == IDLE && fe) bit_cnt <= '0;
      if (state == DATA && fe) begin
        shift   <= {data_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fe || state == IDLE)             wd_cnt <= '0;
      else if (wd_cnt != WW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WW'(1);
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err_d;
      if (state == PARITY && fe) par_bit <= data_s;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign full     = (count == CW'(FIFO_DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_err)       overflow <= 1'b0;
    end
  end

  // NOTE: storage is not reset; rd_data is masked while empty so stale contents never escape.
  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_rx_fifo;

  localparam int HALF  = 20;
  localparam int TO    = 200;
  localparam int DEPTH = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       overflow, frame_err, parity_err;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err), .clear_err(clear_err)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;
  int fe_pulses = 0;
  int pe_pulses = 0;

  // Error outputs are counted per high cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk_clk) begin
    if (frame_err === 1'b1)  fe_pulses++;
    if (parity_err === 1'b1) pe_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  logic       pre_valid, post_valid;
  logic [7:0] pre_data, post_data;
  logic [3:0] pre_count, post_count;

  // Stop-bit edge: two syncs plus the history flop put the push on the third clock edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic pop_at_stop, input logic clr_at_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = stop;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(2);
    pre_valid = rd_valid;
    pre_count = fifo_count;
    pre_data  = rd_data;
    rd_ready  = pop_at_stop;
    clear_err = clr_at_stop;
    tick(1);
    rd_ready   = 1'b0;
    clear_err  = 1'b0;
    post_valid = rd_valid;
    post_count = fifo_count;
    post_data  = rd_data;
    tick(HALF);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_data"}, rd_data, 8'h00);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_perr"}, parity_err, 0);
  endtask

  int exp_fe = 0;
  int exp_pe = 0;

  initial begin
    tick(3);
    check_reset_outputs("reset");
    reset_reset_n = 1'b1;
    tick(5);
    check("no_spurious_fe", fe_pulses, 0);

    // 0x1C has three ones, so odd parity bit is 0.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f1_pre_valid", pre_valid, 0);
    check("f1_pre_count", pre_count, 0);
    check("f1_post_valid", post_valid, 1);
    check("f1_post_data", post_data, 8'h1C);
    check("f1_post_count", post_count, 1);

    // 0xF0 has four ones; parity bit 0 is wrong.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    exp_pe = 1;
    check("bad_par_count", post_count, 1);
`else
    check("bad_par_count", post_count, 2);
`endif
    check("bad_par_perr", pe_pulses, exp_pe);
    check("bad_par_ferr", fe_pulses, exp_fe);
    pop_expect("pop_1c", 8'h1C);
`ifndef PS2_RX_PARITY_CHECK_EN
    pop_expect("pop_f0", 8'hF0);
`endif
    check("drained1", fifo_count, 0);

    // Bad start bit: a falling edge with data high while idle.
    ps2_bit(1'b1);
    tick(HALF);
    exp_fe++;
    check("bad_start_ferr", fe_pulses, exp_fe);

    // Bad stop bit with good parity drops the byte.
    send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0, 1'b0);
    exp_fe++;
    check("bad_stop_count", post_count, 0);
    check("bad_stop_ferr", fe_pulses, exp_fe);
`ifdef PS2_RX_PARITY_CHECK_EN
    send_frame(8'h33, ~odd_par(8'h33), 1'b0, 1'b0, 1'b0);
    exp_fe++;
    exp_pe++;
    check("both_bad_ferr", fe_pulses, exp_fe);
    check("both_bad_perr", pe_pulses, exp_pe);
`endif

    // Fill to depth, then overflow with a ninth byte.
    for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0, 1'b0);
    check("full_count", fifo_count, DEPTH);
    check("full_no_ovf", overflow, 0);
    send_frame(8'h09, odd_par(8'h09), 1'b1, 1'b0, 1'b0);
    check("ovf_count", post_count, DEPTH);
    check("ovf_set", overflow, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Simultaneous push and pop while full.
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, 1'b1, 1'b0);
    check("pp_pre_count", pre_count, DEPTH);
    check("pp_popped", pre_data, 8'h01);
    check("pp_post_count", post_count, DEPTH);
    check("pp_no_ovf", overflow, 0);

    // Overflow in the same cycle as clear_err: overflow wins.
    send_frame(8'h0B, odd_par(8'h0B), 1'b1, 1'b0, 1'b1);
    check("ovf_vs_clear", overflow, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("ovf_cleared2", overflow, 0);

    for (int i = 2; i <= DEPTH; i++) pop_expect($sformatf("drain_%0d", i), 8'(i));
    pop_expect("drain_0a", 8'h0A);
    check("drained2", fifo_count, 0);
    check("drained2_valid", rd_valid, 0);

    // Stall after four data bits until the watchdog fires.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    tick(TO + 20);
    exp_fe++;
    check("timeout_ferr", fe_pulses, exp_fe);
    check("timeout_count", fifo_count, 0);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0, 1'b0);
    check("after_to_count", post_count, 1);
    pop_expect("pop_5a", 8'h5A);

    // Reset mid-frame with three bytes queued.
    send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0, 1'b0);
    check("queued3", fifo_count, 3);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset_reset_n = 1'b0;
    tick(2);
    check_reset_outputs("midreset");
    reset_reset_n = 1'b1;
    tick(5);
    send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0, 1'b0);
    check("post_reset_count", post_count, 1);
    pop_expect("pop_29", 8'h29);
    check("final_count", fifo_count, 0);
    check("final_ferr", fe_pulses, exp_fe);
    check("final_perr", pe_pulses, exp_pe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
